sifh_hist_engine: RTL and testbench
===================================

# sifh_hist_engine

Parametrised multi-pixel SiFH histogram engine for the dToF pipeline. It accumulates SPAD timestamps into per-pixel histograms held in an external simple-dual-port RAM using a pipelined read-modify-write with hazard forwarding. At frame end it scans each pixel's histogram for its peak bin, clearing the RAM as it reads, and hands one peak per pixel downstream over a valid/ready handshake.

## Interface
- `NP`, 16: timestamp width.
- `NB`, 8: bin-index width; bin = `in_tof[NP-1 -: NB]`; requires `NB <= NP`.
- `NPIX`, 4: pixels sharing the RAM, ≥1.
- `CW`, 16: count width.
- Derived: `PW = max(1,$clog2(NPIX))`, `AW = PW+NB`; RAM address = `{pixel, bin}`.

Ports:
- `clk` in 1: single clock.
- `res` in 1: reset, synchronous, active-high.
- `in_valid` in 1: timestamp event valid.
- `in_ready` out 1: engine accepts events.
- `in_pixel` in PW: pixel index of event; values ≥ NPIX are dropped.
- `in_tof` in NP: timestamp.
- `frame_end` in 1: single-cycle frame close request.
- `waddr` out AW: RAM write address.
- `wdata` out CW: RAM write data.
- `wen` out 1: RAM write enable.
- `raddr` out AW: RAM read address.
- `ren` out 1: RAM read enable.
- `rdata` in CW: RAM read data, valid one cycle after `ren`, read-first.
- `peak_valid` out 1: peak result valid.
- `peak_ready` in 1: downstream accepts.
- `peak_pixel` out PW, `peak_bin` out NB, `peak_count` out CW: result.
- `busy` out 1: high in any state except ACCUM.

## Operation
- States: CLEAR, ACCUM, DRAIN, FIND, REPORT.
- CLEAR (entered on reset): write 0 to addresses 0..NPIX·2^NB−1, one per cycle, then ACCUM.
- ACCUM: `in_ready`=1. Event accepted when `in_valid & in_ready`.
  - Stage 0 issues read of the event address.
  - Stage 1 writes `rdata+1` to the same address.
  - Forwarding: if the stage-1 address equals the address written in the previous cycle, use the previously written value instead of `rdata`.
- Overflow: without saturation, counts wrap modulo 2^CW.
- `frame_end` in ACCUM moves to DRAIN. An event in the same cycle is accepted and counted. `frame_end` in any other state is ignored.
- DRAIN: one cycle to retire stage 1, then FIND with pixel 0.
- FIND, per pixel: read bins 0..2^NB−1, one per cycle.
  - Each returned bin writes 0 back to its address (read-clear).
  - Track max count and bin; strict `>` comparison, so ties keep the lowest bin.
  - An all-zero histogram reports bin 0, count 0.
- REPORT: hold `peak_valid` with stable data until `peak_ready`.
  - Then FIND the next pixel, or after pixel NPIX−1 return to ACCUM.
- `res` in any state: abort immediately, restart CLEAR. Any partial histogram is discarded.

## Timing
- Reset values: `in_ready`=0, `wen`=0, `ren`=0, `waddr`=0, `raddr`=0, `wdata`=0, `peak_valid`=0, `peak_pixel`=0, `peak_bin`=0, `peak_count`=0, `busy`=1.
- CLEAR: NPIX·2^NB cycles. `in_ready` rises the cycle after the last clear write.
- Event accepted in cycle t: `ren` in t, `wen` in t+1. Sustained throughput is 1 event/cycle.
- FIND per pixel: 2^NB+1 cycles. `peak_valid` rises the cycle after the last compare.
- Handshake transfer occurs when `peak_valid & peak_ready`. The next pixel's first read is issued in the following cycle.
- `in_ready` drops in the cycle after `frame_end` is accepted.

## Configuration
- `SIFH_SATURATE_EN` defined: counts saturate at 2^CW−1. Forwarded values saturate identically.
- Undefined: counts wrap modulo 2^CW.

## Structure
- Package `sifh_pkg`:
  - state enum;
  - address-compose function `{pixel,bin}`;
  - default-parameter constants.
- Sub-module `sifh_peak_tracker`: max/argmax register pair with clear, update-strobe and strict-greater compare.
- The RAM is external to the engine.

## Test plan
- Reset with NB=4, NPIX=2 -> 32 consecutive `wen` cycles writing 0 to addresses 0..31, then `in_ready`=1.
- Back-to-back events: pixel 1, tof bin 3, ×5 -> final write to address 19 carries 5 (exercises forwarding).
- Interleaved events to bins 2,5,2,5,5, then `frame_end` -> pixel 0 peak bin 5, count 3; RAM reads all 0 afterwards.
- Tie: bins 7 and 2 with 4 hits each -> `peak_bin`=2. `peak_ready` held low for 10 cycles -> outputs stable, no next-pixel reads.
- CW=4, 20 hits on one bin -> count 15 with `SIFH_SATURATE_EN`, count 4 without.
- `res` asserted mid-FIND -> outputs at reset values next cycle, full CLEAR sweep repeated, no `peak_valid` emitted.

Source files
------------

// File: rtl/sifh_hist_engine_pkg.sv
// Shared types and helpers for the SiFH histogram engine.
package sifh_pkg;

    localparam int unsigned SIFH_NP   = 16;
    localparam int unsigned SIFH_NB   = 8;
    localparam int unsigned SIFH_NPIX = 4;
    localparam int unsigned SIFH_CW   = 16;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_ACCUM,
        ST_DRAIN,
        ST_FIND,
        ST_REPORT
    } state_t;

    // RAM address is {pixel, bin}; callers truncate to their address width.
    function automatic int unsigned sifh_addr(input int unsigned pixel,
                                              input int unsigned bin,
                                              input int unsigned nb);
        return (pixel << nb) | bin;
    endfunction

endpackage

// File: rtl/sifh_hist_engine_peak_tracker.sv
// Running max/argmax over a histogram scan; strict compare keeps the lowest bin on ties.
module sifh_peak_tracker #(
    parameter int unsigned NB = 8,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          res,
    input  logic          clr,
    input  logic          upd,
    input  logic [NB-1:0] bin,
    input  logic [CW-1:0] count,
    output logic [NB-1:0] max_bin,
    output logic [CW-1:0] max_count
);

    always_ff @(posedge clk) begin
        if (res || clr) begin
            max_bin   <= '0;
            max_count <= '0;
        end else if (upd && (count > max_count)) begin
            max_bin   <= bin;
            max_count <= count;
        end
    end

endmodule

// File: rtl/sifh_hist_engine.sv
// Multi-pixel SiFH histogram engine: pipelined RMW accumulation into external RAM,
// read-clear peak scan per pixel at frame end. Define SIFH_SATURATE_EN for saturating counts.
module sifh_hist_engine
    import sifh_pkg::*;
#(
    parameter  int unsigned NP   = SIFH_NP,
    parameter  int unsigned NB   = SIFH_NB,
    parameter  int unsigned NPIX = SIFH_NPIX,
    parameter  int unsigned CW   = SIFH_CW,
    localparam int unsigned PW   = (NPIX > 1) ? $clog2(NPIX) : 1,
    localparam int unsigned AW   = PW + NB
) (
    input  logic          clk,
    input  logic          res,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_pixel,
    input  logic [NP-1:0] in_tof,
    input  logic          frame_end,
    output logic [AW-1:0] waddr,
    output logic [CW-1:0] wdata,
    output logic          wen,
    output logic [AW-1:0] raddr,
    output logic          ren,
    input  logic [CW-1:0] rdata,
    output logic          peak_valid,
    input  logic          peak_ready,
    output logic [PW-1:0] peak_pixel,
    output logic [NB-1:0] peak_bin,
    output logic [CW-1:0] peak_count,
    output logic          busy
);

    localparam logic [AW-1:0] CLR_LAST = AW'(NPIX * (2 ** NB) - 1);
    localparam logic [NB-1:0] BIN_LAST = '1;
    localparam logic [PW-1:0] PIX_LAST = PW'(NPIX - 1);
    localparam logic [PW:0]   NPIX_W   = (PW + 1)'(NPIX);

    state_t        state;
    logic          clr_wen;
    logic [AW-1:0] clr_addr;
    logic          s1_valid;
    logic [AW-1:0] s1_addr;
    logic          prev_valid;
    logic [AW-1:0] prev_addr;
    logic [CW-1:0] prev_data;
    logic [PW-1:0] cur_pix;
    logic [NB-1:0] bin_cnt;
    logic          rd_done;
    logic          fz_valid;
    logic [NB-1:0] fz_bin;

    logic          pix_ok;
    logic          ev_rd;
    logic          find_rd;
    logic [AW-1:0] ev_addr;
    logic [AW-1:0] find_raddr;
    logic [AW-1:0] fz_addr;
    logic [CW-1:0] base;
    logic [CW-1:0] inc;
    logic          trk_clr;
    logic          unused_tof;

    assign unused_tof = ^in_tof;

    assign pix_ok     = {1'b0, in_pixel} < NPIX_W;
    assign ev_rd      = in_ready & in_valid & pix_ok;
    assign find_rd    = (state == ST_FIND) & ~rd_done;
    assign ev_addr    = AW'(sifh_addr(32'(in_pixel), 32'(in_tof[NP-1 -: NB]), NB));
    assign find_raddr = AW'(sifh_addr(32'(cur_pix), 32'(bin_cnt), NB));
    assign fz_addr    = AW'(sifh_addr(32'(cur_pix), 32'(fz_bin), NB));

    // Read-first RAM returns stale data when the same address was written last cycle.
    always_comb begin
        base = (prev_valid && (prev_addr == s1_addr)) ? prev_data : rdata;
`ifdef SIFH_SATURATE_EN
        inc = (base == '1) ? base : base + CW'(1);
`else
        inc = base + CW'(1);
`endif
    end

    assign ren   = ev_rd | find_rd;
    assign raddr = find_rd ? find_raddr : (ev_rd ? ev_addr : '0);
    assign wen   = s1_valid | clr_wen | fz_valid;
    assign waddr = s1_valid ? s1_addr : (clr_wen ? clr_addr : (fz_valid ? fz_addr : '0));
    assign wdata = s1_valid ? inc : '0;
    assign busy  = (state != ST_ACCUM);

    assign trk_clr    = (state == ST_DRAIN) | ((state == ST_REPORT) & peak_ready);
    assign peak_pixel = cur_pix;

    sifh_peak_tracker #(
        .NB(NB),
        .CW(CW)
    ) u_tracker (
        .clk      (clk),
        .res      (res),
        .clr      (trk_clr),
        .upd      (fz_valid),
        .bin      (fz_bin),
        .count    (rdata),
        .max_bin  (peak_bin),
        .max_count(peak_count)
    );

    always_ff @(posedge clk) begin
        if (res) begin
            state      <= ST_CLEAR;
            clr_wen    <= 1'b0;
            clr_addr   <= '0;
            in_ready   <= 1'b0;
            s1_valid   <= 1'b0;
            s1_addr    <= '0;
            prev_valid <= 1'b0;
            prev_addr  <= '0;
            prev_data  <= '0;
            cur_pix    <= '0;
            bin_cnt    <= '0;
            rd_done    <= 1'b0;
            fz_valid   <= 1'b0;
            fz_bin     <= '0;
            peak_valid <= 1'b0;
        end else begin
            s1_valid   <= ev_rd;
            s1_addr    <= ev_addr;
            prev_valid <= s1_valid;
            prev_addr  <= s1_addr;
            prev_data  <= inc;
            fz_valid   <= find_rd;
            fz_bin     <= bin_cnt;

            case (state)
                ST_CLEAR: begin
                    if (!clr_wen) begin
                        clr_wen <= 1'b1;
                    end else if (clr_addr == CLR_LAST) begin
                        clr_wen  <= 1'b0;
                        state    <= ST_ACCUM;
                        in_ready <= 1'b1;
                    end else begin
                        clr_addr <= clr_addr + AW'(1);
                    end
                end
                ST_ACCUM: begin
                    if (frame_end) begin
                        state    <= ST_DRAIN;
                        in_ready <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    state   <= ST_FIND;
                    cur_pix <= '0;
                    bin_cnt <= '0;
                    rd_done <= 1'b0;
                end
                ST_FIND: begin
                    if (find_rd) begin
                        if (bin_cnt == BIN_LAST) rd_done <= 1'b1;
                        else                     bin_cnt <= bin_cnt + NB'(1);
                    end
                    if (fz_valid && (fz_bin == BIN_LAST)) begin
                        state      <= ST_REPORT;
                        peak_valid <= 1'b1;
                    end
                end
                ST_REPORT: begin
                    if (peak_ready) begin
                        peak_valid <= 1'b0;
                        if (cur_pix == PIX_LAST) begin
                            state    <= ST_ACCUM;
                            in_ready <= 1'b1;
                        end else begin
                            state   <= ST_FIND;
                            cur_pix <= cur_pix + PW'(1);
                            bin_cnt <= '0;
                            rd_done <= 1'b0;
                        end
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_sifh_hist_engine.sv
// Directed bench for sifh_hist_engine (NB=4, NPIX=2, CW=4) with a read-first RAM model.
module tb_sifh_hist_engine;

    logic       clk = 1'b0;
    logic       res;
    logic       in_valid;
    logic       in_ready;
    logic [0:0] in_pixel;
    logic [7:0] in_tof;
    logic       frame_end;
    logic [4:0] waddr;
    logic [3:0] wdata;
    logic       wen;
    logic [4:0] raddr;
    logic       ren;
    logic [3:0] rdata = '0;
    logic       peak_valid;
    logic       peak_ready;
    logic [0:0] peak_pixel;
    logic [3:0] peak_bin;
    logic [3:0] peak_count;
    logic       busy;

    int checks   = 0;
    int failures = 0;

`ifdef SIFH_SATURATE_EN
    localparam logic [3:0] SAT_EXP = 4'd15;
`else
    localparam logic [3:0] SAT_EXP = 4'd4;
`endif

    always #5 clk = ~clk;

    sifh_hist_engine #(
        .NP  (8),
        .NB  (4),
        .NPIX(2),
        .CW  (4)
    ) dut (
        .clk       (clk),
        .res       (res),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .in_tof    (in_tof),
        .frame_end (frame_end),
        .waddr     (waddr),
        .wdata     (wdata),
        .wen       (wen),
        .raddr     (raddr),
        .ren       (ren),
        .rdata     (rdata),
        .peak_valid(peak_valid),
        .peak_ready(peak_ready),
        .peak_pixel(peak_pixel),
        .peak_bin  (peak_bin),
        .peak_count(peak_count),
        .busy      (busy)
    );

    // Read-first simple-dual-port RAM, one-cycle read latency.
    logic [3:0] mem [32];
    logic [3:0] last_w19 = '0;

    initial for (int i = 0; i < 32; i++) mem[i] = 4'hA;

    always @(posedge clk) begin
        if (ren) rdata <= mem[raddr];
        if (wen) mem[waddr] <= wdata;
        if (wen && waddr == 5'd19 && wdata != 4'd0) last_w19 <= wdata;
    end

    // Event byte: bit7 valid, bit4 pixel, bits3:0 bin.
    typedef struct {
        string           name;
        int              n;
        logic [7:0][7:0] ev;
        logic [3:0]      b0, c0, b1, c1;
    } vec_t;

    function automatic logic [7:0][7:0] evl(input logic [7:0] e0, e1, e2, e3, e4, e5, e6, e7);
        logic [7:0][7:0] r;
        r[0] = e0; r[1] = e1; r[2] = e2; r[3] = e3;
        r[4] = e4; r[5] = e5; r[6] = e6; r[7] = e7;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int ram_nonzero();
        int nz = 0;
        for (int i = 0; i < 32; i++) if (mem[i] != 4'd0) nz++;
        return nz;
    endfunction

    task automatic check_reset_vals(input string nm);
        chk({nm, ":in_ready"}, in_ready, 0);
        chk({nm, ":wen"}, wen, 0);
        chk({nm, ":ren"}, ren, 0);
        chk({nm, ":waddr"}, waddr, 0);
        chk({nm, ":raddr"}, raddr, 0);
        chk({nm, ":wdata"}, wdata, 0);
        chk({nm, ":peak_valid"}, peak_valid, 0);
        chk({nm, ":peak_pixel"}, peak_pixel, 0);
        chk({nm, ":peak_bin"}, peak_bin, 0);
        chk({nm, ":peak_count"}, peak_count, 0);
        chk({nm, ":busy"}, busy, 1);
    endtask

    // Entered at the first clear-write cycle.
    task automatic sweep(input string nm);
        for (int i = 0; i < 32; i++) begin
            #1;
            chk({nm, ":clr_wen"}, wen, 1);
            chk({nm, ":clr_addr"}, waddr, i);
            chk({nm, ":clr_data"}, wdata, 0);
            chk({nm, ":clr_rdy_pv"}, {in_ready, peak_valid}, 0);
            tick();
        end
        #1;
        chk({nm, ":ready_up"}, in_ready, 1);
        chk({nm, ":busy_low"}, busy, 0);
        chk({nm, ":clr_done_wen"}, wen, 0);
        tick();
    endtask

    task automatic send(input logic [7:0] e, input logic fe);
        in_valid  = e[7];
        in_pixel  = e[4];
        in_tof    = {e[3:0], 4'($urandom)};
        frame_end = fe;
        tick();
        in_valid  = 1'b0;
        frame_end = 1'b0;
    endtask

    task automatic wait_peak(input string nm, output int n);
        n = 0;
        while (!peak_valid && n < 100) begin
            tick();
            #1;
            n++;
        end
        chk({nm, ":peak_tmo"}, peak_valid, 1);
    endtask

    // Entered in the DRAIN cycle, peak_ready high.
    task automatic collect(input string nm, input logic [3:0] b0, c0, b1, c1);
        int n;
        #1;
        chk({nm, ":ready_drop"}, in_ready, 0);
        for (int p = 0; p < 2; p++) begin
            wait_peak(nm, n);
            if (p == 0) chk({nm, ":find_lat"}, n, 18);
            chk({nm, ":pixel"}, peak_pixel, p);
            chk({nm, ":bin"}, peak_bin, (p == 0) ? b0 : b1);
            chk({nm, ":count"}, peak_count, (p == 0) ? c0 : c1);
            tick();
            #1;
            if (p == 0) begin
                chk({nm, ":next_ren"}, ren, 1);
                chk({nm, ":next_raddr"}, raddr, 16);
            end
        end
        chk({nm, ":ready_back"}, in_ready, 1);
        chk({nm, ":ram_cleared"}, ram_nonzero(), 0);
        tick();
    endtask

    vec_t vecs[6];

    initial begin
        int n;
        vecs[0] = '{"fwd5",  5, evl(8'h93, 8'h93, 8'h93, 8'h93, 8'h93, 8'h00, 8'h00, 8'h00),
                   4'h0, 4'd0, 4'h3, 4'd5};
        vecs[1] = '{"inter", 5, evl(8'h82, 8'h85, 8'h82, 8'h85, 8'h85, 8'h00, 8'h00, 8'h00),
                   4'h5, 4'd3, 4'h0, 4'd0};
        vecs[2] = '{"mix",   6, evl(8'h90, 8'h8F, 8'h90, 8'h8F, 8'h91, 8'h90, 8'h00, 8'h00),
                   4'hF, 4'd2, 4'h0, 4'd3};
        vecs[3] = '{"gaps",  7, evl(8'h84, 8'h00, 8'h84, 8'h00, 8'h00, 8'h84, 8'h89, 8'h00),
                   4'h4, 4'd3, 4'h0, 4'd0};
        vecs[4] = '{"empty", 1, evl(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00),
                   4'h0, 4'd0, 4'h0, 4'd0};
        vecs[5] = '{"p1wide", 7, evl(8'h9A, 8'h9A, 8'h9B, 8'h9A, 8'h9B, 8'h9B, 8'h9B, 8'h00),
                   4'h0, 4'd0, 4'hB, 4'd4};

        res = 1'b1; in_valid = 1'b0; in_pixel = '0; in_tof = '0;
        frame_end = 1'b0; peak_ready = 1'b1;
        repeat (3) tick();
        #1;
        check_reset_vals("reset");
        res = 1'b0;
        tick();
        sweep("clear0");

        // Single event: read in cycle t, write in t+1.
        in_valid = 1'b1; in_pixel = 1'b0; in_tof = 8'h95;
        #1;
        chk("ev_ren", ren, 1);
        chk("ev_raddr", raddr, 9);
        tick();
        in_valid = 1'b0;
        #1;
        chk("ev_wen", wen, 1);
        chk("ev_waddr", waddr, 9);
        chk("ev_wdata", wdata, 1);
        tick();
        send(8'h00, 1'b1);
        collect("single", 4'h9, 4'd1, 4'h0, 4'd0);

        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < vecs[i].n; j++) send(vecs[i].ev[j], (j == vecs[i].n - 1));
            collect(vecs[i].name, vecs[i].b0, vecs[i].c0, vecs[i].b1, vecs[i].c1);
            if (i == 0) chk("fwd_w19", last_w19, 5);
        end

        // Tie plus backpressure: peak must hold and no next-pixel reads issue.
        peak_ready = 1'b0;
        for (int k = 0; k < 8; k++) send((k % 2 != 0) ? 8'h82 : 8'h87, (k == 7));
        #1;
        wait_peak("tie", n);
        for (int k = 0; k < 10; k++) begin
            chk("tie:hold_valid", peak_valid, 1);
            chk("tie:bin", peak_bin, 2);
            chk("tie:count", peak_count, 4);
            chk("tie:pixel", peak_pixel, 0);
            chk("tie:no_ren", ren, 0);
            tick();
            #1;
        end
        peak_ready = 1'b1;
        tick();
        #1;
        chk("tie:next_ren", ren, 1);
        chk("tie:next_raddr", raddr, 16);
        wait_peak("tie_p1", n);
        chk("tie_p1:pixel", peak_pixel, 1);
        chk("tie_p1:count", peak_count, 0);
        tick();
        #1;
        chk("tie:ready_back", in_ready, 1);
        tick();

        for (int k = 0; k < 20; k++) send(8'h86, (k == 19));
        collect("overflow", 4'h6, SAT_EXP, 4'h0, 4'd0);

        // Reset in the middle of the peak scan.
        for (int k = 0; k < 3; k++) send(8'h81, (k == 2));
        repeat (6) tick();
        res = 1'b1;
        tick();
        res = 1'b0;
        #1;
        check_reset_vals("midfind");
        tick();
        sweep("clear1");
        send(8'h00, 1'b1);
        collect("post_res", 4'h0, 4'd0, 4'h0, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
